// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between instruction fetch and data requesters.
// Optional ARB_STARVE_GUARD_EN forces an instruction grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        arb_err
);
  typedef enum logic [2:0] {IDLE, I_ACC, D_ACC, I_DONE, D_DONE} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic [TW-1:0] tcnt;
  logic d_req, grant_i, acc, req;
  assign d_req = dREN | dWEN;
  assign acc = (state == I_ACC) || (state == D_ACC);
  assign req = (state == I_ACC) ? iREN : d_req;
`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] scnt;
  logic unused_ok;
  assign unused_ok = ^{iaddr[1:0], daddr[1:0]};
  assign grant_i = iREN && (!d_req || scnt == SW'(STARVE_LIMIT));
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) scnt <= '0;
    else if (state == IDLE && (grant_i || d_req))
      scnt <= (grant_i || !iREN) ? '0 : scnt + 1'b1;
`else
  logic unused_ok;
  assign unused_ok = ^{iaddr[1:0], daddr[1:0], 3'(STARVE_LIMIT)};
  assign grant_i = iREN && !d_req;
`endif
  // Strobes follow state combinationally so an async reset drops them at once.
  assign ramREN = (state == I_ACC) || (state == D_ACC && !dWEN);
  assign ramWEN = (state == D_ACC) && dWEN;
  assign ramaddr = (state == I_ACC) ? {iaddr[31:2], 2'b00} :
                   (state == D_ACC) ? {daddr[31:2], 2'b00} : '0;
  assign ramstore = ramWEN ? dstore : '0;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      tcnt <= '0;
      ihit <= 1'b0;
      dhit <= 1'b0;
      arb_err <= 1'b0;
      iload <= '0;
      dload <= '0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      arb_err <= 1'b0;
      if (state == IDLE) begin
        tcnt <= '0;
        if (grant_i) state <= I_ACC;
        else if (d_req) state <= D_ACC;
      end else if (acc) begin
        if (!req) state <= IDLE;
        else if (ram_ready) begin
          if (state == I_ACC) begin
            iload <= ramload;
            ihit <= 1'b1;
            state <= I_DONE;
          end else begin
            if (!dWEN) dload <= ramload;
            dhit <= 1'b1;
            state <= D_DONE;
          end
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state <= IDLE;
          arb_err <= 1'b1;
        end else tcnt <= tcnt + 1'b1;
      end else state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic CLK = 1'b0, nRST = 1'b0;
  logic iREN = 0, dREN = 0, dWEN = 0, ram_ready = 0, use_mem = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ram_val = 0;
  logic ihit, dhit, ramREN, ramWEN, arb_err;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  localparam logic [31:0] K = 32'hC0DE_0000;
  typedef struct {logic [2:0] kind; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  logic [31:0] exp_iload = 0, exp_dload = 0;
  assign ramload = use_mem ? (ramaddr ^ K) : ram_val;
  always #5 CLK = ~CLK;
  mem_port_arbiter dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .arb_err(arb_err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge CLK);
  endtask
  task automatic push(input logic [2:0] kind, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask
  // Completion monitor: every hit/error pulse must match the next scoreboard entry.
  always @(negedge CLK) begin
    exp_t e;
    if (nRST) begin
      check("exclusive", {ihit & dhit, ramREN & ramWEN}, 0);
      if (ihit | dhit | arb_err) begin
        if (sb.size() == 0) check("unexpected_evt", {ihit, dhit, arb_err}, 0);
        else begin
          e = sb.pop_front();
          check("evt_kind", {ihit, dhit, arb_err}, e.kind);
          check("evt_data", dhit ? dload : iload, e.data);
        end
      end
    end
  end
  initial begin
    tick();
    tick();
    check("rst_flags", {ihit, dhit, arb_err, ramREN, ramWEN}, 0);
    check("rst_loads", {iload, dload}, 0);
    check("rst_ram", {ramaddr, ramstore}, 0);
    nRST = 1;
    tick();
    // instruction read, minimum latency
    iREN = 1; iaddr = 32'h0000_0104;
    tick();
    check("i_strobe", {ramREN, ramWEN}, 2'b10);
    check("i_addr", ramaddr, 32'h104);
    ram_ready = 1; ram_val = 32'h2001_0005;
    exp_iload = ram_val; push(3'b100, exp_iload);
    tick();
    iREN = 0; ram_ready = 0;
    check("i_done_strobe", {ramREN, ramWEN}, 0);
    tick();
    check("i_idle", {ihit, ramREN}, 0);
    // contention: data write wins, instruction follows
    iREN = 1; iaddr = 32'h300; dWEN = 1; daddr = 32'h203; dstore = 32'hDEAD_BEEF;
    tick();
    check("w_strobe", {ramREN, ramWEN}, 2'b01);
    check("w_addr", ramaddr, 32'h200);
    check("w_store", ramstore, 32'hDEAD_BEEF);
    ram_ready = 1; ram_val = 32'h5555_5555;
    push(3'b010, exp_dload);
    tick();
    dWEN = 0; ram_ready = 0;
    tick();
    check("c_idle", {ramREN, ramWEN}, 0);
    tick();
    check("c_i_strobe", {ramREN, ramWEN}, 2'b10);
    check("c_i_addr", ramaddr, 32'h300);
    ram_ready = 1; ram_val = 32'hA5A5_0001;
    exp_iload = ram_val; push(3'b100, exp_iload);
    tick();
    iREN = 0; ram_ready = 0;
    tick();
    // wait states
    dREN = 1; daddr = 32'h40;
    tick();
    for (int k = 0; k < 6; k++) begin
      check("ws_ren", {ramREN, ramWEN}, 2'b10);
      if (k == 5) begin
        ram_ready = 1; ram_val = 32'h1234_5678;
        exp_dload = ram_val; push(3'b010, exp_dload);
      end
      tick();
    end
    dREN = 0; ram_ready = 0;
    tick();
    // timeout then re-grant, then abort
    iREN = 1; iaddr = 32'h80;
    push(3'b001, exp_iload);
    tick();
    for (int k = 0; k < 16; k++) begin
      check("to_ren", ramREN, 1);
      tick();
    end
    check("to_idle", ramREN, 0);
    tick();
    check("to_regrant", ramREN, 1);
    iREN = 0;
    tick();
    check("to_abort", ramREN, 0);
    // data abort at ACC cycle 2
    dREN = 1; daddr = 32'h10;
    tick();
    check("ab_c1", ramREN, 1);
    tick();
    check("ab_c2", ramREN, 1);
    dREN = 0;
    tick();
    check("ab_low", {ramREN, ramWEN}, 0);
    tick();
    check("ab_quiet", {ramREN, dhit}, 0);
    // async reset mid write access
    dWEN = 1; daddr = 32'h44; dstore = 32'h1;
    tick();
    check("ra_wen", ramWEN, 1);
    #2 nRST = 0;
    #1;
    check("ra_strobe", {ramREN, ramWEN, ihit, dhit, arb_err}, 0);
    check("ra_ram", {ramaddr, ramstore}, 0);
    check("ra_loads", {iload, dload}, 0);
    exp_iload = 0; exp_dload = 0;
    dWEN = 0;
    tick();
    nRST = 1;
    tick();
    // sustained contention with ready always high
    iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h100; ram_ready = 1; use_mem = 1;
    for (int t = 0; t < 10; t++) begin
`ifdef ARB_STARVE_GUARD_EN
      if (t % 5 == 4) push(3'b100, 32'h200 ^ K);
      else push(3'b010, 32'h100 ^ K);
`else
      push(3'b010, 32'h100 ^ K);
`endif
    end
    for (int t = 0; t < 29; t++) tick();
    iREN = 0; dREN = 0; ram_ready = 0; use_mem = 0;
    tick();
    tick();
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester and the data (MEM-stage) requester of the pipelined datapath.
- Registered FSM: arbitrates, drives RAM strobes, waits on RAM ready with a timeout, then returns a one-cycle hit pulse plus registered load data.
- Sits between the datapath's imem/dmem request signals and the memory model or bus.

Parameters:
- TIMEOUT_CYCLES, 16, RAM cycles to wait for ram_ready before aborting with error (>=2)
- STARVE_LIMIT, 4, consecutive data grants with iREN pending before instruction is forced (used only with the optional feature)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request, held until ihit
- iaddr  in  32  instruction byte address
- dREN  in  1  data read request, held until dhit
- dWEN  in  1  data write request, held until dhit
- daddr  in  32  data byte address
- dstore  in  32  data write value
- ihit  out  1  one-cycle instruction completion pulse
- dhit  out  1  one-cycle data completion pulse
- iload  out  32  registered instruction word
- dload  out  32  registered data read word
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address, bits[1:0] forced 0
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid with ram_ready
- ram_ready  in  1  RAM access complete this cycle
- arb_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- States: IDLE, I_ACC, D_ACC, I_DONE, D_DONE. Reset state IDLE.
- Reset values: ihit=0, dhit=0, iload=0, dload=0, arb_err=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, timeout counter=0.
- IDLE: (dREN|dWEN) -> D_ACC. Else iREN -> I_ACC. Else stay. Data wins over instruction when both request; the MEM stage is older.
- I_ACC: ramREN=1, ramaddr={iaddr[31:2],2'b00}.
- D_ACC: ramaddr={daddr[31:2],2'b00}.
  - dWEN=1: ramWEN=1, ramstore=dstore.
  - Else: ramREN=1.
  - dWEN takes precedence when dREN and dWEN are both set. ramREN and ramWEN are never high together.
- RAM strobes and address are combinational from state and the granted requester's inputs. They are 0 outside the ACC states.
- ram_ready=1 in an ACC state (sampled at the edge):
  - Capture ramload into iload (I_ACC) or dload (D_ACC read; dload unchanged on write).
  - Go to I_DONE or D_DONE.
- I_DONE: ihit=1 for exactly one cycle, then IDLE. D_DONE: dhit=1 for exactly one cycle, then IDLE.
- Minimum latency: request seen in IDLE at cycle 0, strobe at cycle 1, ram_ready at cycle 1, hit at cycle 2, IDLE at cycle 3.
- Timeout:
  - Counter clears on ACC entry and increments each ACC cycle without ram_ready.
  - On reaching TIMEOUT_CYCLES: go to IDLE, arb_err=1 for one cycle, no hit, loads unchanged.
- Abort: the granted request drops before ram_ready (e.g. halt flush). Strobes fall next cycle, state goes to IDLE, no hit, no arb_err.
- ram_ready outside the ACC states is ignored.
- Reset mid-access: strobes deassert immediately (asynchronous) and the FSM returns to IDLE. Any partial access is discarded.
- Exactly one of ihit/dhit can be high in a cycle; never both.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A 3+-bit counter increments on each IDLE->D_ACC transition taken while iREN=1.
  - When the count equals STARVE_LIMIT, the next IDLE arbitration with iREN=1 grants I_ACC even if data is requesting.
  - Counter clears on any I_ACC grant, on any data grant with iREN=0, and on reset.
- Not defined: no counter; data always wins in IDLE.

Test Plan:
- Instruction read: iREN=1, iaddr=0x0000_0104, ram_ready at cycle 1 with ramload=0x2001_0005 -> ramaddr=0x104, ramREN=1 at cycle 1; ihit=1 and iload=0x2001_0005 at cycle 2; IDLE at cycle 3.
- Contention: iREN=1 and dWEN=1 (daddr=0x203, dstore=0xDEAD_BEEF) together -> D_ACC first with ramWEN=1, ramaddr=0x200, ramstore=0xDEADBEEF; dhit, then IDLE, then I_ACC; dload unchanged.
- Wait states: dREN=1, ram_ready held low 5 cycles then high with ramload=0x1234_5678 -> ramREN high for 6 cycles; dhit one cycle later with dload=0x12345678; no arb_err.
- Timeout: TIMEOUT_CYCLES=16, iREN=1, ram_ready never asserted -> after 16 ACC cycles arb_err pulses once, FSM in IDLE, ihit never asserted, then re-grants I_ACC.
- Reset and abort:
  - nRST low mid-D_ACC -> ramREN/ramWEN drop in the same cycle; all outputs at reset values.
  - Separately, dREN dropped at ACC cycle 2 -> strobes low next cycle, no dhit.
- ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, iREN and dREN held continuously with ram_ready=1 -> grant order D,D,D,D,I,D,... Without the macro -> data-only grants.
